// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester/response/ALU bus for the two-port shared ALU arbiter
package alu_share_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_type;
endpackage

interface alu_share_arbiter_if #(
    parameter int DATA_LENGTH = 32
);
    import alu_share_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    alu_op_type             req_op0;
    alu_op_type             req_op1;
    logic [DATA_LENGTH-1:0] req_a0;
    logic [DATA_LENGTH-1:0] req_b0;
    logic [DATA_LENGTH-1:0] req_a1;
    logic [DATA_LENGTH-1:0] req_b1;
    logic                   flush;
    logic [1:0]             resp_valid;
    logic [1:0]             resp_ready;
    logic [DATA_LENGTH-1:0] resp_data;
    logic                   resp_ge;
    logic                   resp_eq;
    alu_op_type             alu_op;
    logic [DATA_LENGTH-1:0] alu_in1;
    logic [DATA_LENGTH-1:0] alu_in2;
    logic                   alu_jal;
    logic                   alu_jalr;
    logic                   alu_branch_capture;
    logic [DATA_LENGTH-1:0] alu_out;
    logic                   alu_ge;
    logic                   alu_eq;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  flush, resp_ready, alu_out, alu_ge, alu_eq,
        output req_ready, resp_valid, resp_data, resp_ge, resp_eq,
        output alu_op, alu_in1, alu_in2, alu_jal, alu_jalr, alu_branch_capture
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output flush, resp_ready, alu_out, alu_ge, alu_eq,
        input  req_ready, resp_valid, resp_data, resp_ge, resp_eq,
        input  alu_op, alu_in1, alu_in2, alu_jal, alu_jalr, alu_branch_capture
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_LENGTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_last_grant;
    logic                   r_grant;
    alu_op_type             r_op;
    logic [DATA_LENGTH-1:0] r_a;
    logic [DATA_LENGTH-1:0] r_b;
    logic [1:0]             r_resp_valid;
    logic [DATA_LENGTH-1:0] r_resp_data;
    logic                   r_resp_ge;
    logic                   r_resp_eq;

    logic                   w_grant;
    logic [1:0]             w_req_ready;
    logic                   w_accept;

    // On contention the requester that did not win last time gets the ALU.
    always_comb begin
        w_grant     = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
        w_req_ready = 2'b00;
        if (r_state == IDLE && !bus.flush && !rst && (|bus.req_valid)) begin
            w_req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_accept = |(bus.req_valid & w_req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op         <= ALU_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_ge    <= 1'b0;
            r_resp_eq    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_grant ? bus.req_op1 : bus.req_op0;
                        r_a          <= w_grant ? bus.req_a1  : bus.req_a0;
                        r_b          <= w_grant ? bus.req_b1  : bus.req_b0;
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_resp_data  <= bus.alu_out;
                        r_resp_ge    <= bus.alu_ge;
                        r_resp_eq    <= bus.alu_eq;
                        r_resp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    // Flush wins over a simultaneous handshake; ready on the other bit is ignored.
                    if (bus.flush || bus.resp_ready[r_grant]) begin
                        r_resp_valid <= 2'b00;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 2'b00;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready          = w_req_ready;
    assign bus.resp_valid         = r_resp_valid;
    assign bus.resp_data          = r_resp_data;
    assign bus.resp_ge            = r_resp_ge;
    assign bus.resp_eq            = r_resp_eq;
    assign bus.alu_op             = (r_state == EXEC) ? r_op : ALU_ADD;
    assign bus.alu_in1            = (r_state == EXEC) ? r_a  : '0;
    assign bus.alu_in2            = (r_state == EXEC) ? r_b  : '0;
    assign bus.alu_jal            = 1'b0;
    assign bus.alu_jalr           = 1'b0;
    assign bus.alu_branch_capture = 1'b0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   m_last;

    alu_share_arbiter_if #(.DATA_LENGTH(DW)) bus();

    alu_share_arbiter #(.DATA_LENGTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input alu_op_type op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        bus.alu_out = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
        bus.alu_ge  = $signed(bus.alu_in1) >= $signed(bus.alu_in2);
        bus.alu_eq  = bus.alu_in1 == bus.alu_in2;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b11) return 1 - m_last;
        return v[1] ? 1 : 0;
    endfunction

    // Entered and left at a negedge with the arbiter idle.
    task automatic run_txn(input logic [1:0] v,
                           input alu_op_type o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input alu_op_type o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                           input int bp, input bit wrong, input int eg, input logic [DW-1:0] ed);
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
        logic [1:0]    gmask;
        wa    = (eg == 1) ? a1 : a0;
        wb    = (eg == 1) ? b1 : b0;
        gmask = (eg == 1) ? 2'b10 : 2'b01;
        bus.req_valid = v;
        bus.req_op0 = o0; bus.req_a0 = a0; bus.req_b0 = b0;
        bus.req_op1 = o1; bus.req_a1 = a1; bus.req_b1 = b1;
        #1;
        chk("req_ready_grant", bus.req_ready, gmask);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("exec_alu_in1", bus.alu_in1, wa);
        chk("exec_alu_in2", bus.alu_in2, wb);
        chk("exec_no_resp", bus.resp_valid, 2'b00);
        @(negedge clk);
        #1;
        chk("resp_valid", bus.resp_valid, gmask);
        chk("resp_data", bus.resp_data, ed);
        chk("resp_ge", bus.resp_ge, $signed(wa) >= $signed(wb));
        chk("resp_eq", bus.resp_eq, wa == wb);
        for (int i = 0; i < bp; i++) begin
            bus.req_valid  = 2'b11;
            bus.resp_ready = wrong ? ~gmask : 2'b00;
            #1;
            chk("bp_req_ready", bus.req_ready, 2'b00);
            @(negedge clk);
            #1;
            chk("bp_resp_valid", bus.resp_valid, gmask);
            chk("bp_resp_data", bus.resp_data, ed);
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = gmask;
        @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        chk("after_hs_resp_valid", bus.resp_valid, 2'b00);
        m_last = eg;
    endtask

    typedef struct {
        logic [1:0]    v;
        alu_op_type    o0;
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        alu_op_type    o1;
        logic [DW-1:0] a1;
        logic [DW-1:0] b1;
        int            bp;
        bit            wrong;
        int            eg;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_last = 1;
        tbl[0] = '{2'b11, ALU_SUB, 32'd10, 32'd3, ALU_XOR, 32'hF0, 32'h0F, 0, 1'b0, 0, 32'd7};
        tbl[1] = '{2'b11, ALU_SUB, 32'd10, 32'd3, ALU_XOR, 32'hF0, 32'h0F, 0, 1'b0, 1, 32'hFF};
        tbl[2] = '{2'b11, ALU_SUB, 32'd10, 32'd3, ALU_XOR, 32'hF0, 32'h0F, 0, 1'b0, 0, 32'd7};
        tbl[3] = '{2'b01, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 4, 1'b0, 0, 32'd12};
        tbl[4] = '{2'b10, ALU_ADD, 32'd1, 32'd1, ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 2, 1'b1, 1, 32'h0F000F00};
        tbl[5] = '{2'b11, ALU_OR, 32'h12340000, 32'h5678, ALU_ADD, 32'd9, 32'd9, 1, 1'b1, 0, 32'h12345678};
        tbl[6] = '{2'b10, ALU_ADD, 32'd0, 32'd0, ALU_SUB, 32'd0, 32'd1, 0, 1'b0, 1, 32'hFFFFFFFF};

        rst = 1'b1;
        bus.req_valid = 2'b11; bus.resp_ready = 2'b00; bus.flush = 1'b0;
        bus.req_op0 = ALU_SUB; bus.req_op1 = ALU_XOR;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_a1 = 32'd3; bus.req_b1 = 32'd4;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_flags", {bus.resp_ge, bus.resp_eq}, 2'b00);
        chk("rst_alu_op", bus.alu_op, ALU_ADD);
        chk("rst_alu_in", {bus.alu_in1, bus.alu_in2}, 0);
        chk("tied_zero", {bus.alu_jal, bus.alu_jalr, bus.alu_branch_capture}, 3'b000);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_txn(tbl[i].v, tbl[i].o0, tbl[i].a0, tbl[i].b0, tbl[i].o1, tbl[i].a1, tbl[i].b1,
                    tbl[i].bp, tbl[i].wrong, tbl[i].eg, tbl[i].ed);
        end

        // Flush during EXEC: accept req1, abort it, then a tie must still favour req0.
        bus.req_valid = 2'b10; bus.req_op1 = ALU_SUB; bus.req_a1 = 32'd50; bus.req_b1 = 32'd8;
        #1;
        chk("flush_accept", bus.req_ready, 2'b10);
        @(negedge clk);
        m_last = 1;
        bus.req_valid = 2'b00;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        chk("flush_no_resp", bus.resp_valid, 2'b00);
        chk("flush_idle_ready", bus.req_ready, 2'b00);
        bus.flush = 1'b0;
        bus.req_valid = 2'b00;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("flush_quiet", bus.resp_valid, 2'b00);
        end
        run_txn(2'b11, ALU_ADD, 32'd2, 32'd3, ALU_ADD, 32'd4, 32'd4, 0, 1'b0, model_grant(2'b11), 32'd5);

        // Reset while a response is pending.
        bus.req_valid = 2'b01; bus.req_op0 = ALU_ADD; bus.req_a0 = 32'd1; bus.req_b0 = 32'd2;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("prerst_resp_valid", bus.resp_valid, 2'b01);
        bus.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", bus.resp_valid, 2'b00);
        chk("midrst_resp_data", bus.resp_data, 0);
        chk("midrst_req_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        m_last = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("postrst_quiet", bus.resp_valid, 2'b00);
        end
        run_txn(2'b11, ALU_XOR, 32'hAA, 32'h55, ALU_SUB, 32'd1, 32'd1, 0, 1'b0, model_grant(2'b11), 32'hFF);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]    v;
            alu_op_type    o0;
            alu_op_type    o1;
            logic [DW-1:0] a0, b0, a1, b1;
            int            eg;
            v  = 2'($urandom_range(1, 3));
            o0 = alu_op_type'($urandom_range(0, 7));
            o1 = alu_op_type'($urandom_range(0, 7));
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = $urandom;
            eg = model_grant(v);
            run_txn(v, o0, a0, b0, o1, a1, b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), eg,
                    (eg == 1) ? alu_f(o1, a1, b1) : alu_f(o0, a0, b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
